// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_pkg
//  Brief    : Shared RV32I constants and the IF/ID pipeline-register record.
//  Revision : 1.0
// ============================================================================
package rv32i_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]             instr;
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] pcplus4;
    logic                    valid;
  } ifid_t;

  // Canonical bubble: a NOP tagged invalid with zeroed PCs.
  function automatic ifid_t ifid_bubble();
    ifid_t b;
    b.instr   = NOP_INSTR;
    b.pc      = '0;
    b.pcplus4 = '0;
    b.valid   = 1'b0;
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_reg
//  Brief    : IF/ID pipeline register; reset > flush > stall > capture.
//  Revision : 1.0
// ============================================================================
module if_id_reg
  import rv32i_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_flush,
  input  logic  i_stall,
  input  ifid_t i_d,
  output ifid_t o_q
);

  ifid_t r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= ifid_bubble();
    end else if (i_flush) begin
      r_q <= ifid_bubble();
    end else if (!i_stall) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Brief    : RV32I fetch stage: PC, next-PC mux, IF/ID register, perf counters
//             (counters built only when FETCH_PERF_EN is defined).
//  Revision : 1.0
// ============================================================================
module fetch_stage
  import rv32i_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_f_i,
  input  logic            stall_d_i,
  input  logic            flush_d_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_target_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [31:0]     imem_rdata_i,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pcplus4_d,
  output logic            valid_d,
  output logic            misalign_o,
  output logic [31:0]     fetch_count_o,
  output logic [31:0]     flush_count_o
);

  logic [XLEN-1:0] r_pc_f;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_pc_next;
  logic            r_misalign;
  logic            w_bubble;
  logic            w_capture;
  ifid_t           w_ifid_d;
  ifid_t           w_ifid_q;

  assign w_pc_plus4 = r_pc_f + XLEN'(4);

  always_comb begin
    w_pc_next = w_pc_plus4;
    if (redirect_i) begin
      w_pc_next = {redirect_target_i[XLEN-1:2], 2'b00};
    end else if (stall_f_i) begin
      w_pc_next = r_pc_f;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_f     <= RESET_PC;
      r_misalign <= 1'b0;
    end else begin
      r_pc_f     <= w_pc_next;
      r_misalign <= redirect_i & (|redirect_target_i[1:0]);
    end
  end

  // A redirect also squashes the wrong-path word fetched this cycle.
  assign w_bubble  = flush_d_i | redirect_i;
  assign w_capture = ~w_bubble & ~stall_d_i;

  always_comb begin
    w_ifid_d.instr   = imem_rdata_i;
    w_ifid_d.pc      = r_pc_f;
    w_ifid_d.pcplus4 = w_pc_plus4;
    w_ifid_d.valid   = 1'b1;
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_bubble),
    .i_stall (stall_d_i),
    .i_d     (w_ifid_d),
    .o_q     (w_ifid_q)
  );

  assign imem_addr_o = r_pc_f;
  assign instr_d     = w_ifid_q.instr;
  assign pc_d        = w_ifid_q.pc;
  assign pcplus4_d   = w_ifid_q.pcplus4;
  assign valid_d     = w_ifid_q.valid;
  assign misalign_o  = r_misalign;

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_flush_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_capture) r_fetch_count <= r_fetch_count + 32'd1;
      if (w_bubble)  r_flush_count <= r_flush_count + 32'd1;
    end
  end

  assign fetch_count_o = r_fetch_count;
  assign flush_count_o = r_flush_count;
`else
  logic w_unused_capture;
  assign w_unused_capture = w_capture;
  assign fetch_count_o    = 32'h0;
  assign flush_count_o    = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Brief    : Scoreboard bench for fetch_stage; ROM word i holds value i.
//  Revision : 1.0
// ============================================================================
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f_i, stall_d_i, flush_d_i, redirect_i;
  logic [31:0] redirect_target_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic [31:0] instr_d, pc_d, pcplus4_d;
  logic        valid_d, misalign_o;
  logic [31:0] fetch_count_o, flush_count_o;

  always #5 clk = ~clk;

  assign imem_rdata_i = {2'b00, imem_addr_o[31:2]};

  fetch_stage dut (
    .clk               (clk),
    .rst               (rst),
    .stall_f_i         (stall_f_i),
    .stall_d_i         (stall_d_i),
    .flush_d_i         (flush_d_i),
    .redirect_i        (redirect_i),
    .redirect_target_i (redirect_target_i),
    .imem_addr_o       (imem_addr_o),
    .imem_rdata_i      (imem_rdata_i),
    .instr_d           (instr_d),
    .pc_d              (pc_d),
    .pcplus4_d         (pcplus4_d),
    .valid_d           (valid_d),
    .misalign_o        (misalign_o),
    .fetch_count_o     (fetch_count_o),
    .flush_count_o     (flush_count_o)
  );

  localparam int S_PC = 0, S_INSTR = 1, S_PCD = 2, S_PCP4 = 3,
                 S_VALID = 4, S_MIS = 5, S_FCNT = 6, S_FLCNT = 7;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   edge_cnt = 0;
  int   n_total  = 0;
  int   n_pass   = 0;

  function automatic logic [31:0] actual(int sig);
    case (sig)
      S_PC:    return imem_addr_o;
      S_INSTR: return instr_d;
      S_PCD:   return pc_d;
      S_PCP4:  return pcplus4_d;
      S_VALID: return {31'd0, valid_d};
      S_MIS:   return {31'd0, misalign_o};
      S_FCNT:  return fetch_count_o;
      default: return flush_count_o;
    endcase
  endfunction

  // Counter expectations collapse to zero when the counters are not built.
  function automatic logic [31:0] cnt(logic [31:0] v);
`ifdef FETCH_PERF_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  // Expectation for the state visible after the next rising edge.
  task automatic expect_nx(string name, int sig, logic [31:0] val);
    exp_t e;
    e.cyc = edge_cnt + 1; e.sig = sig; e.val = val; e.name = name;
    q.push_back(e);
  endtask

  task automatic expect_ifid(string tag, logic [31:0] pc, logic [31:0] ins,
                             logic [31:0] pcd, logic [31:0] p4, logic v);
    expect_nx({tag, ".pc_f"},      S_PC,    pc);
    expect_nx({tag, ".instr_d"},   S_INSTR, ins);
    expect_nx({tag, ".pc_d"},      S_PCD,   pcd);
    expect_nx({tag, ".pcplus4_d"}, S_PCP4,  p4);
    expect_nx({tag, ".valid_d"},   S_VALID, {31'd0, v});
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    stall_f_i = 0; stall_d_i = 0; flush_d_i = 0; redirect_i = 0;
  endtask

  always @(posedge clk) begin
    edge_cnt = edge_cnt + 1;
    #1;
    while (q.size() > 0 && q[0].cyc <= edge_cnt) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = actual(e.sig);
      n_total++;
      if (e.cyc == edge_cnt && a === e.val) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, a, e.val);
    end
  end

  initial begin
    rst = 1; idle(); redirect_target_i = 32'h0;

    // Reset state
    expect_ifid("rst", 32'h0, 32'h13, 32'h0, 32'h0, 1'b0);
    expect_nx("rst.misalign", S_MIS, 32'h0);
    expect_nx("rst.fcnt", S_FCNT, 32'h0);
    expect_nx("rst.flcnt", S_FLCNT, 32'h0);
    step();
    rst = 0;

    // Free run three edges
    step(); step();
    expect_ifid("run3", 32'd12, 32'd2, 32'd8, 32'd12, 1'b1);
    step();
    n_total++;
    if (imem_addr_o === 32'd12 && instr_d === 32'd2) n_pass++;
    else $display("FAIL direct.run3: pc_f 0x%08h instr_d 0x%08h", imem_addr_o, instr_d);
    expect_ifid("run4", 32'd16, 32'd3, 32'd12, 32'd16, 1'b1);
    step();

    // Full stall for two cycles
    stall_f_i = 1; stall_d_i = 1;
    expect_ifid("stall1", 32'd16, 32'd3, 32'd12, 32'd16, 1'b1);
    step();
    expect_ifid("stall2", 32'd16, 32'd3, 32'd12, 32'd16, 1'b1);
    step();
    idle();
    expect_ifid("unstall", 32'd20, 32'd4, 32'd16, 32'd20, 1'b1);
    step();
    n_total++;
    if (imem_addr_o === 32'd20) n_pass++;
    else $display("FAIL direct.unstall: pc_f 0x%08h", imem_addr_o);

    // Redirect beats stall_f; one bubble, then target
    redirect_i = 1; stall_f_i = 1; redirect_target_i = 32'h100;
    expect_ifid("redir", 32'h100, 32'h13, 32'h0, 32'h0, 1'b0);
    expect_nx("redir.misalign", S_MIS, 32'h0);
    step();
    n_total++;
    if (imem_addr_o === 32'h100 && valid_d === 1'b0) n_pass++;
    else $display("FAIL direct.redir: pc_f 0x%08h valid_d %b", imem_addr_o, valid_d);
    idle();
    expect_ifid("redir_tgt", 32'h104, 32'h40, 32'h100, 32'h104, 1'b1);
    step();

    // Flush beats stall_d; PC still advances
    flush_d_i = 1; stall_d_i = 1;
    expect_ifid("flush", 32'h108, 32'h13, 32'h0, 32'h0, 1'b0);
    step();
    idle();
    expect_ifid("postflush", 32'h10C, 32'h42, 32'h108, 32'h10C, 1'b1);
    step();

    // Misaligned redirect: aligned PC, one-cycle misalign pulse
    redirect_i = 1; redirect_target_i = 32'h102;
    expect_nx("mis.pc_f", S_PC, 32'h100);
    expect_nx("mis.pulse", S_MIS, 32'h1);
    step();
    n_total++;
    if (imem_addr_o === 32'h100 && misalign_o === 1'b1) n_pass++;
    else $display("FAIL direct.mis: pc_f 0x%08h misalign %b", imem_addr_o, misalign_o);
    idle();
    expect_nx("mis.clear", S_MIS, 32'h0);
    expect_ifid("mis_tgt", 32'h104, 32'h40, 32'h100, 32'h104, 1'b1);
    step();

    // PC wrap at top of address space
    redirect_i = 1; redirect_target_i = 32'hFFFF_FFFC;
    expect_nx("top.pc_f", S_PC, 32'hFFFF_FFFC);
    step();
    idle();
    expect_ifid("wrap", 32'h0, 32'h3FFF_FFFF, 32'hFFFF_FFFC, 32'h0, 1'b1);
    step();

    // stall_f alone: IF/ID recaptures the same PC
    stall_f_i = 1;
    expect_ifid("sf1", 32'h0, 32'h0, 32'h0, 32'h4, 1'b1);
    step();
    expect_ifid("sf2", 32'h0, 32'h0, 32'h0, 32'h4, 1'b1);
    step();
    idle();

    // Reset mid-operation dominates a misaligned redirect
    rst = 1; redirect_i = 1; redirect_target_i = 32'h103;
    expect_ifid("rst2", 32'h0, 32'h13, 32'h0, 32'h0, 1'b0);
    expect_nx("rst2.misalign", S_MIS, 32'h0);
    expect_nx("rst2.fcnt", S_FCNT, 32'h0);
    expect_nx("rst2.flcnt", S_FLCNT, 32'h0);
    step();
    rst = 0; idle();

    // Counters: 10 captures then 2 redirects
    for (int i = 0; i < 9; i++) step();
    expect_nx("perf10.fcnt", S_FCNT, cnt(32'd10));
    expect_nx("perf10.flcnt", S_FLCNT, cnt(32'd0));
    step();
    redirect_i = 1; redirect_target_i = 32'h200;
    step();
    expect_nx("perf.fcnt", S_FCNT, cnt(32'd10));
    expect_nx("perf.flcnt", S_FLCNT, cnt(32'd2));
    step();
    n_total++;
    if (fetch_count_o === cnt(32'd10) && flush_count_o === cnt(32'd2)) n_pass++;
    else $display("FAIL direct.perf: fcnt 0x%08h flcnt 0x%08h", fetch_count_o, flush_count_o);
    idle();
    step(); step();

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_total++;
      $display("FAIL %s: got no sample expected 0x%08h", e.name, e.val);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
